// File: rtl/vita49_sched_pkg.sv
// Shared types for the VITA-49 transmit burst scheduler: FSM states, packer
// ctrl bit positions and the queued burst command record.
package vita49_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    RST   = 3'd2,
    ARM   = 3'd3,
    RUN   = 3'd4,
    DONE  = 3'd5,
    FLUSH = 3'd6
  } state_t;

  localparam int CTRL_START = 0;
  localparam int CTRL_RESET = 1;

  // 1 + 32 + 16 + 32 + 32 + 64 = 177 bits
  typedef struct packed {
    logic        timed;
    logic [31:0] stream_id;
    logic [15:0] pkt_size;
    logic [31:0] words;
    logic [31:0] start_sec;
    logic [63:0] start_fsec;
  } cmd_t;

  // A burst with no packets or no payload cannot be handed to the packer.
  function automatic logic cmd_is_empty(input cmd_t c);
    return (c.pkt_size == 16'd0) || (c.words == 32'd0);
  endfunction

endpackage

// File: rtl/vita49_cmd_fifo.sv
// Single-clock command FIFO with first-word-fall-through read, flush and
// occupancy; QDEPTH must be a power of two so the pointers wrap naturally.
module vita49_cmd_fifo
  import vita49_sched_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  cmd_t                     din,
  output cmd_t                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  level
);

  localparam int AW = $clog2(QDEPTH);

  cmd_t          mem [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(QDEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/vita49_tx_sched.sv
// Burst sequencer for vita49_pack: queues commands, programs the packer,
// pulses its reset, waits for the start time and runs until the last packet.
module vita49_tx_sched
  import vita49_sched_pkg::*;
#(
  parameter int QDEPTH     = 4,
  parameter int RST_CYCLES = 4,
  parameter int TIMEOUT    = 65536,
  parameter bit LATE_DROP  = 1'b0
) (
  input  logic                        AXIS_ACLK,
  input  logic                        AXIS_ARESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_timed,
  input  logic [31:0]                 cmd_stream_id,
  input  logic [15:0]                 cmd_pkt_size,
  input  logic [31:0]                 cmd_words,
  input  logic [31:0]                 cmd_start_sec,
  input  logic [63:0]                 cmd_start_fsec,
  input  logic                        abort,
  input  logic [31:0]                 timestamp_sec,
  input  logic [63:0]                 timestamp_fsec,
  output logic [31:0]                 ctrl,
  output logic [31:0]                 streamID,
  output logic [15:0]                 pkt_size,
  output logic [31:0]                 words_to_pack,
  input  logic                        mon_tvalid,
  input  logic                        mon_tready,
  input  logic                        mon_tlast,
  output logic                        busy,
  output logic                        done,
  output logic                        late_err,
  output logic                        cfg_err,
  output logic                        timeout_err,
  input  logic                        err_clr,
  output logic [31:0]                 pkt_count,
  output logic [$clog2(QDEPTH):0]     q_level
);

  localparam int CW = $clog2(RST_CYCLES + 1);

  state_t        state;
  cmd_t          work;
  cmd_t          cmd_in;
  cmd_t          fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [31:0]   rem;
  logic [31:0]   wd;
  logic [CW-1:0] cnt;
  logic          arm_first;
  logic          abort_hit;
  logic          beat;
  logic [95:0]   now;
  logic [95:0]   tgt;
  logic          late_set;
  logic          cfg_set;
  logic          tmo_set;

  assign cmd_in    = {cmd_timed, cmd_stream_id, cmd_pkt_size, cmd_words, cmd_start_sec, cmd_start_fsec};
  // Abort is a no-op only when there is nothing queued and nothing running.
  assign abort_hit = abort & ~((state == IDLE) & fifo_empty);
  assign fifo_push = cmd_valid & ~fifo_full & ~abort;
  assign fifo_pop  = (state == IDLE) & ~fifo_empty & ~abort_hit;
  assign beat      = mon_tvalid & mon_tready & mon_tlast;
  assign now       = {timestamp_sec, timestamp_fsec};
  assign tgt       = {work.start_sec, work.start_fsec};

  assign cfg_set  = ~abort_hit & (state == CHECK) & cmd_is_empty(work);
  assign late_set = ~abort_hit & (state == ARM) & work.timed & arm_first & (now > tgt);
  assign tmo_set  = ~abort_hit & (state == RUN) & ~beat & (wd == 32'(TIMEOUT - 1));

  vita49_cmd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk   (AXIS_ACLK),
    .rst   (AXIS_ARESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (abort_hit),
    .din   (cmd_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      state         <= IDLE;
      work          <= '0;
      streamID      <= '0;
      pkt_size      <= '0;
      words_to_pack <= '0;
      rem           <= '0;
      wd            <= '0;
      cnt           <= '0;
      arm_first     <= 1'b0;
      pkt_count     <= '0;
    end else if (abort_hit) begin
      state <= FLUSH;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) begin
          work  <= fifo_dout;
          state <= CHECK;
        end
        CHECK: if (cmd_is_empty(work)) begin
          state <= IDLE;
        end else begin
          streamID      <= work.stream_id;
          pkt_size      <= work.pkt_size;
          words_to_pack <= work.words;
          rem           <= work.words;
          cnt           <= '0;
          state         <= RST;
        end
        RST: if (cnt == CW'(RST_CYCLES - 1)) begin
          state     <= ARM;
          arm_first <= 1'b1;
        end else begin
          cnt <= cnt + CW'(1);
        end
        ARM: begin
          arm_first <= 1'b0;
          wd        <= '0;
          // A late command always satisfies now >= tgt, so it runs unless dropped.
          if (late_set && LATE_DROP) state <= IDLE;
          else if (!work.timed || now >= tgt) state <= RUN;
        end
        RUN: if (beat) begin
          pkt_count <= pkt_count + 32'd1;
          wd        <= '0;
          if (rem <= {16'd0, pkt_size}) state <= DONE;
          else rem <= rem - {16'd0, pkt_size};
        end else if (tmo_set) begin
          state <= FLUSH;
          cnt   <= '0;
        end else begin
          wd <= wd + 32'd1;
        end
        DONE: state <= IDLE;
        FLUSH: if (cnt == CW'(RST_CYCLES - 1)) state <= IDLE;
               else cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  // A set in the same cycle as err_clr takes precedence.
  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      late_err    <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      late_err    <= late_set | (late_err & ~err_clr);
      cfg_err     <= cfg_set | (cfg_err & ~err_clr);
      timeout_err <= tmo_set | (timeout_err & ~err_clr);
    end
  end

  always_comb begin
    ctrl             = '0;
    ctrl[CTRL_START] = (state == RUN);
    ctrl[CTRL_RESET] = (state == RST) || (state == FLUSH);
  end

  assign done      = (state == DONE);
  assign busy      = (state != IDLE) || !fifo_empty;
  assign cmd_ready = !fifo_full;

endmodule

// File: tb/tb_vita49_tx_sched.sv
// Directed and randomized bench for vita49_tx_sched, checked every cycle
// against a transaction-level model of the burst scheduler.
module tb_vita49_tx_sched;
  import vita49_sched_pkg::*;

  localparam int QDEPTH     = 4;
  localparam int RST_CYCLES = 4;
  localparam int TIMEOUT    = 16;
  localparam bit LATE_DROP  = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_timed;
  logic [31:0] cmd_stream_id, cmd_words, cmd_start_sec;
  logic [15:0] cmd_pkt_size;
  logic [63:0] cmd_start_fsec;
  logic        abort;
  logic [31:0] timestamp_sec;
  logic [63:0] timestamp_fsec;
  logic [31:0] ctrl, streamID, words_to_pack, pkt_count;
  logic [15:0] pkt_size;
  logic        mon_tvalid, mon_tready, mon_tlast;
  logic        busy, done, late_err, cfg_err, timeout_err, err_clr;
  logic [2:0]  q_level;

  int checks = 0;
  int errors = 0;
  logic [95:0] now_t = '0;

  vita49_tx_sched #(
    .QDEPTH(QDEPTH), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .LATE_DROP(LATE_DROP)
  ) dut (
    .AXIS_ACLK(clk), .AXIS_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_timed(cmd_timed),
    .cmd_stream_id(cmd_stream_id), .cmd_pkt_size(cmd_pkt_size), .cmd_words(cmd_words),
    .cmd_start_sec(cmd_start_sec), .cmd_start_fsec(cmd_start_fsec), .abort(abort),
    .timestamp_sec(timestamp_sec), .timestamp_fsec(timestamp_fsec),
    .ctrl(ctrl), .streamID(streamID), .pkt_size(pkt_size), .words_to_pack(words_to_pack),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .busy(busy), .done(done), .late_err(late_err), .cfg_err(cfg_err),
    .timeout_err(timeout_err), .err_clr(err_clr), .pkt_count(pkt_count), .q_level(q_level)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_IDLE, P_CHECK, P_RESET, P_WAIT, P_RUN, P_DONE, P_FLUSH} phase_e;
  cmd_t        mq[$];
  cmd_t        cur = '0;
  cmd_t        incoming;
  phase_e      ph = P_IDLE;
  longint      need = 0, sent = 0;
  int          quiet = 0, left = 0;
  bit          first = 0;
  bit          m_late = 0, m_cfg = 0, m_tmo = 0;
  logic [31:0] m_pkts = '0, m_sid = '0, m_words = '0;
  logic [15:0] m_psz = '0;
  bit          push_ok, s_late, s_cfg, s_tmo, m_beat;
  logic [95:0] m_now, m_tgt;

  task automatic go_run();
    ph = P_RUN;
    quiet = 0;
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete(); ph = P_IDLE; cur = '0; m_late = 0; m_cfg = 0; m_tmo = 0;
      m_pkts = '0; m_sid = '0; m_words = '0; m_psz = '0;
    end else begin
      push_ok = cmd_valid && (mq.size() < QDEPTH) && !abort;
      incoming = {cmd_timed, cmd_stream_id, cmd_pkt_size, cmd_words, cmd_start_sec, cmd_start_fsec};
      s_late = 0; s_cfg = 0; s_tmo = 0;
      m_beat = mon_tvalid && mon_tready && mon_tlast;
      m_now = {timestamp_sec, timestamp_fsec};
      m_tgt = {cur.start_sec, cur.start_fsec};
      if (abort && !(ph == P_IDLE && mq.size() == 0)) begin
        mq.delete();
        ph = P_FLUSH;
        left = RST_CYCLES;
      end else begin
        case (ph)
          P_IDLE: if (mq.size() > 0) begin cur = mq.pop_front(); ph = P_CHECK; end
          P_CHECK: if (cur.pkt_size == 0 || cur.words == 0) begin
            s_cfg = 1; ph = P_IDLE;
          end else begin
            m_sid = cur.stream_id; m_psz = cur.pkt_size; m_words = cur.words;
            need = (longint'(cur.words) + longint'(cur.pkt_size) - 1) / longint'(cur.pkt_size);
            sent = 0; ph = P_RESET; left = RST_CYCLES; first = 1;
          end
          P_RESET: begin left--; if (left == 0) ph = P_WAIT; end
          P_WAIT: begin
            if (!cur.timed) go_run();
            else if (first && m_now > m_tgt) begin
              s_late = 1;
              if (LATE_DROP) ph = P_IDLE; else go_run();
            end else if (m_now >= m_tgt) go_run();
            first = 0;
          end
          P_RUN: if (m_beat) begin
            m_pkts++; sent++; quiet = 0;
            if (sent == need) ph = P_DONE;
          end else begin
            quiet++;
            if (quiet == TIMEOUT) begin s_tmo = 1; ph = P_FLUSH; left = RST_CYCLES; end
          end
          P_DONE: ph = P_IDLE;
          P_FLUSH: begin left--; if (left == 0) ph = P_IDLE; end
          default: ph = P_IDLE;
        endcase
        if (push_ok) mq.push_back(incoming);
      end
      m_late = s_late || (m_late && !err_clr);
      m_cfg  = s_cfg  || (m_cfg  && !err_clr);
      m_tmo  = s_tmo  || (m_tmo  && !err_clr);
    end
  end

  // Compare every output against the model once per cycle.
  initial forever begin
    @(negedge clk);
    check("ctrl", ctrl, (ph == P_RESET || ph == P_FLUSH) ? 32'h2 : (ph == P_RUN) ? 32'h1 : 32'h0);
    check("done", done, ph == P_DONE);
    check("busy", busy, (ph != P_IDLE) || (mq.size() > 0));
    check("cmd_ready", cmd_ready, mq.size() < QDEPTH);
    check("q_level", q_level, 96'(mq.size()));
    check("late_err", late_err, m_late);
    check("cfg_err", cfg_err, m_cfg);
    check("timeout_err", timeout_err, m_tmo);
    check("pkt_count", pkt_count, m_pkts);
    check("streamID", streamID, m_sid);
    check("pkt_size", pkt_size, m_psz);
    check("words_to_pack", words_to_pack, m_words);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    now_t = now_t + 96'd1;
    timestamp_sec  = now_t[95:64];
    timestamp_fsec = now_t[63:0];
  endtask

  task automatic set_time(input logic [95:0] t);
    now_t = t;
    timestamp_sec  = now_t[95:64];
    timestamp_fsec = now_t[63:0];
  endtask

  task automatic push_cmd(input logic timed, input logic [31:0] id, input logic [15:0] psz,
                          input logic [31:0] words, input logic [31:0] sec, input logic [63:0] fsec);
    cmd_valid = 1; cmd_timed = timed; cmd_stream_id = id; cmd_pkt_size = psz;
    cmd_words = words; cmd_start_sec = sec; cmd_start_fsec = fsec;
    step();
    cmd_valid = 0;
  endtask

  task automatic beat();
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 1;
    step();
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
  endtask

  task automatic wait_ctrl(input logic [31:0] v, input int maxc);
    int n = 0;
    while (ctrl !== v && n < maxc) begin step(); n++; end
    check("wait_ctrl", ctrl, v);
  endtask

  task automatic count_while(input logic [31:0] v, input int maxc, output int n);
    n = 0;
    while (ctrl === v && n < maxc) begin n++; step(); end
  endtask

  task automatic pulse_clr();
    err_clr = 1; step(); err_clr = 0;
  endtask

  int n;
  logic [95:0] tmp;

  initial begin
    rst = 1; cmd_valid = 0; cmd_timed = 0; cmd_stream_id = 0; cmd_pkt_size = 0;
    cmd_words = 0; cmd_start_sec = 0; cmd_start_fsec = 0; abort = 0; err_clr = 0;
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
    set_time('0);
    repeat (3) step();
    check("rst_ctrl", ctrl, 32'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 0;
    step();

    // Untimed 0x40 words in 0x20-word packets: 4 reset cycles, two TLASTs.
    push_cmd(0, 32'hdeadbeef, 16'h20, 32'h40, 0, 0);
    wait_ctrl(32'h2, 10);
    count_while(32'h2, 20, n);
    check("t1_rst_cycles", n, 4);
    check("t1_stream_id", streamID, 32'hdeadbeef);
    wait_ctrl(32'h1, 5);
    beat();
    check("t1_no_done_yet", done, 1'b0);
    repeat (2) step();
    beat();
    check("t1_done", done, 1'b1);
    check("t1_pkt_count", pkt_count, 32'd2);
    step();
    check("t1_ctrl_idle", ctrl, 32'h0);

    // Timed start at (5, 0x100) from (4, -16): start rises the cycle after equality.
    set_time({32'd4, 64'hFFFF_FFFF_FFFF_FFF0});
    push_cmd(1, 32'h1234, 16'h20, 32'h20, 32'd5, 64'h100);
    wait_ctrl(32'h1, 400);
    check("t2_start_time", now_t, {32'd5, 64'h101});
    check("t2_late", late_err, 1'b0);
    beat();
    check("t2_done", done, 1'b1);

    // Timed start in the past: flagged late, runs anyway.
    push_cmd(1, 32'h55, 16'h10, 32'h10, 32'd1, 64'h0);
    wait_ctrl(32'h1, 20);
    check("t3_late", late_err, 1'b1);
    beat();
    check("t3_pkt_count", pkt_count, 32'd4);
    pulse_clr();
    check("t3_late_clr", late_err, 1'b0);

    // 0x50 words in 0x20-word packets needs three TLASTs.
    push_cmd(0, 32'h77, 16'h20, 32'h50, 0, 0);
    wait_ctrl(32'h1, 20);
    beat(); beat();
    check("t4_two_beats", done, 1'b0);
    beat();
    check("t4_done", done, 1'b1);
    check("t4_pkt_count", pkt_count, 32'd7);
    step();
    push_cmd(0, 32'h88, 16'h0, 32'h10, 0, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin step(); if (ctrl !== 32'h0) n++; end
    check("t4_cfg_no_ctrl", n, 0);
    check("t4_cfg_err", cfg_err, 1'b1);
    pulse_clr();

    // Fill the queue behind a running burst, then abort it.
    push_cmd(0, 32'hA, 16'h10, 32'h100, 0, 0);
    push_cmd(0, 32'hB, 16'h10, 32'h10, 0, 0);
    push_cmd(0, 32'hC, 16'h10, 32'h10, 0, 0);
    push_cmd(0, 32'hD, 16'h10, 32'h10, 0, 0);
    push_cmd(0, 32'hE, 16'h10, 32'h10, 0, 0);
    check("t5_full_level", q_level, 3'd4);
    check("t5_not_ready", cmd_ready, 1'b0);
    push_cmd(0, 32'hF, 16'h10, 32'h10, 0, 0);
    check("t5_drop_level", q_level, 3'd4);
    wait_ctrl(32'h1, 20);
    abort = 1; step(); abort = 0;
    check("t5_q_flushed", q_level, 3'd0);
    count_while(32'h2, 20, n);
    check("t5_flush_cycles", n, 4);
    check("t5_busy", busy, 1'b0);

    // Stalled output: watchdog fires after TIMEOUT run cycles.
    push_cmd(0, 32'h99, 16'h10, 32'h40, 0, 0);
    wait_ctrl(32'h1, 20);
    count_while(32'h1, 100, n);
    check("t6_run_cycles", n, TIMEOUT);
    check("t6_timeout", timeout_err, 1'b1);
    repeat (6) step();
    pulse_clr();
    check("t6_timeout_clr", timeout_err, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cmd_valid      = ($urandom_range(0, 3) == 0);
      cmd_timed      = 1'($urandom_range(0, 1));
      cmd_stream_id  = $urandom;
      cmd_pkt_size   = 16'($urandom_range(0, 8));
      cmd_words      = 32'($urandom_range(0, 40));
      tmp            = now_t + 96'($urandom_range(0, 80)) - 96'd20;
      cmd_start_sec  = tmp[95:64];
      cmd_start_fsec = tmp[63:0];
      mon_tvalid     = ($urandom_range(0, 3) != 0);
      mon_tready     = ($urandom_range(0, 3) != 0);
      mon_tlast      = ($urandom_range(0, 2) == 0);
      abort          = ($urandom_range(0, 299) == 0);
      err_clr        = ($urandom_range(0, 99) == 0);
      step();
    end
    cmd_valid = 0; mon_tvalid = 0; mon_tready = 0; mon_tlast = 0; err_clr = 0;
    abort = 1; step(); abort = 0;
    repeat (8) step();
    check("end_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
